// File: rtl/cpu_pkg.sv
// Shared widths, write-back FSM states and the latched memory-request payload.
package cpu_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  dst;
  } mem_req_t;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/wb_mem_timer.sv
// Cycle counter for an outstanding memory request; flags the last allowed cycle.
module wb_mem_timer
  import cpu_pkg::*;
#(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned W = timer_width(LIMIT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: retires ALU results, runs the data-memory handshake,
// stalls upstream while a memory op is outstanding and drives the register-file write port.
module write_back
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              exe_en,
  input  logic [REG_W-1:0]  exe_dst_reg,
  input  logic [DATA_W-1:0] exe_out,
  input  logic              exe_mem_en,
  input  logic              exe_mem_write,
  input  logic [ADDR_W-1:0] exe_mem_addr,
  input  logic [DATA_W-1:0] exe_mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_stall,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_dst_reg,
  output logic [DATA_W-1:0] wb_out,
  output logic              mem_fault,
  output logic [CNT_W-1:0]  retire_cnt
);

  wb_state_t         state_q,      state_d;
  mem_req_t          req_q,        req_d;
  logic              mem_req_q,    mem_req_d;
  logic              wb_stall_q,   wb_stall_d;
  logic              wb_en_q,      wb_en_d;
  logic [REG_W-1:0]  wb_dst_q,     wb_dst_d;
  logic [DATA_W-1:0] wb_out_q,     wb_out_d;
  logic              mem_fault_q,  mem_fault_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired_c;

  wb_mem_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk       (cpu_clk),
    .rst       (cpu_rst),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .expired_c (tmr_expired_c)
  );

  // Next-state and output computation; exe_* is ignored outside IDLE.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    mem_req_d    = mem_req_q;
    wb_en_d      = 1'b0;
    wb_dst_d     = wb_dst_q;
    wb_out_d     = wb_out_q;
    mem_fault_d  = mem_fault_q;
    retire_cnt_d = retire_cnt_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (exe_en) begin
          if (exe_mem_en) begin
            req_d.we    = exe_mem_write;
            req_d.addr  = exe_mem_addr;
            req_d.wdata = exe_mem_wdata;
            req_d.dst   = exe_dst_reg;
            mem_req_d   = 1'b1;
            tmr_clr     = 1'b1;
            state_d     = MEM_WAIT;
          end else begin
            wb_en_d      = 1'b1;
            wb_dst_d     = exe_dst_reg;
            wb_out_d     = exe_out;
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          retire_cnt_d = retire_cnt_q + CNT_W'(1);
          state_d      = IDLE;
          if (!req_q.we) begin
            wb_en_d  = 1'b1;
            wb_dst_d = req_q.dst;
            wb_out_d = mem_rdata;
          end
        end else if (tmr_expired_c) begin
          mem_req_d   = 1'b0;
          mem_fault_d = 1'b1;
          state_d     = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    wb_stall_d = (state_d == MEM_WAIT);
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      mem_req_q    <= 1'b0;
      wb_stall_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_dst_q     <= '0;
      wb_out_q     <= '0;
      mem_fault_q  <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      mem_req_q    <= mem_req_d;
      wb_stall_q   <= wb_stall_d;
      wb_en_q      <= wb_en_d;
      wb_dst_q     <= wb_dst_d;
      wb_out_q     <= wb_out_d;
      mem_fault_q  <= mem_fault_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = req_q.we;
  assign mem_addr   = req_q.addr;
  assign mem_wdata  = req_q.wdata;
  assign wb_stall   = wb_stall_q;
  assign wb_en      = wb_en_q;
  assign wb_dst_reg = wb_dst_q;
  assign wb_out     = wb_out_q;
  assign mem_fault  = mem_fault_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: ALU retire, load/store handshake, timeout, reset, ordering.
module tb_write_back;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        exe_en;
  logic [3:0]  exe_dst_reg;
  logic [15:0] exe_out;
  logic        exe_mem_en;
  logic        exe_mem_write;
  logic [31:0] exe_mem_addr;
  logic [15:0] exe_mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        wb_stall;
  logic        wb_en;
  logic [3:0]  wb_dst_reg;
  logic [15:0] wb_out;
  logic        mem_fault;
  logic [15:0] retire_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 cpu_clk = ~cpu_clk;

  write_back #(.MEM_TIMEOUT(64)) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst       (cpu_rst),
    .exe_en        (exe_en),
    .exe_dst_reg   (exe_dst_reg),
    .exe_out       (exe_out),
    .exe_mem_en    (exe_mem_en),
    .exe_mem_write (exe_mem_write),
    .exe_mem_addr  (exe_mem_addr),
    .exe_mem_wdata (exe_mem_wdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .wb_stall      (wb_stall),
    .wb_en         (wb_en),
    .wb_dst_reg    (wb_dst_reg),
    .wb_out        (wb_out),
    .mem_fault     (mem_fault),
    .retire_cnt    (retire_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive_alu(input logic [3:0] dst, input logic [15:0] val);
    exe_en = 1'b1; exe_mem_en = 1'b0; exe_dst_reg = dst; exe_out = val;
  endtask

  task automatic drive_mem(input logic wr, input logic [31:0] addr,
                           input logic [15:0] wd, input logic [3:0] dst);
    exe_en = 1'b1; exe_mem_en = 1'b1; exe_mem_write = wr;
    exe_mem_addr = addr; exe_mem_wdata = wd; exe_dst_reg = dst;
  endtask

  initial begin
    int n;
    cpu_rst = 1'b1; exe_en = 1'b0; exe_dst_reg = '0; exe_out = '0; exe_mem_en = 1'b0;
    exe_mem_write = 1'b0; exe_mem_addr = '0; exe_mem_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_req", 32'(mem_req), 0);
    check("rst_stall", 32'(wb_stall), 0);
    check("rst_wb_en", 32'(wb_en), 0);
    check("rst_out", 32'(wb_out), 0);
    check("rst_fault", 32'(mem_fault), 0);
    check("rst_retire", 32'(retire_cnt), 0);
    cpu_rst = 1'b0;
    step();

    // single ALU op
    drive_alu(4'd3, 16'hBEEF);
    step();
    check("alu_en", 32'(wb_en), 1);
    check("alu_dst", 32'(wb_dst_reg), 3);
    check("alu_out", 32'(wb_out), 32'hBEEF);
    check("alu_retire", 32'(retire_cnt), 1);
    exe_en = 1'b0;
    step();
    check("idle_en", 32'(wb_en), 0);
    check("idle_hold_out", 32'(wb_out), 32'hBEEF);

    // back-to-back ALU ops
    drive_alu(4'd1, 16'h1111);
    step();
    check("b2b1_out", 32'(wb_out), 32'h1111);
    drive_alu(4'd2, 16'h2222);
    step();
    check("b2b2_en", 32'(wb_en), 1);
    check("b2b2_dst", 32'(wb_dst_reg), 2);
    check("b2b2_out", 32'(wb_out), 32'h2222);
    check("b2b_retire", 32'(retire_cnt), 3);
    exe_en = 1'b0;

    // load with ack after 3 stall cycles
    drive_mem(1'b0, 32'h0001_0040, 16'h0000, 4'd5);
    step();
    exe_en = 1'b0;
    check("ld_req", 32'(mem_req), 1);
    check("ld_we", 32'(mem_we), 0);
    check("ld_addr", mem_addr, 32'h0001_0040);
    check("ld_wb_en", 32'(wb_en), 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (wb_stall) n++;
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 16'h1234; end
      step();
    end
    mem_ack = 1'b0;
    check("ld_stall_cycles", 32'(n), 3);
    check("ld_wb_en1", 32'(wb_en), 1);
    check("ld_dst", 32'(wb_dst_reg), 5);
    check("ld_out", 32'(wb_out), 32'h1234);
    check("ld_req_drop", 32'(mem_req), 0);
    check("ld_stall_drop", 32'(wb_stall), 0);
    check("ld_retire", 32'(retire_cnt), 4);

    // store, ack after 1 extra cycle
    drive_mem(1'b1, 32'h0000_0020, 16'hA5A5, 4'd8);
    step();
    exe_en = 1'b0;
    check("st_we", 32'(mem_we), 1);
    check("st_addr", mem_addr, 32'h20);
    check("st_wdata", 32'(mem_wdata), 32'hA5A5);
    step();
    check("st_req_held", 32'(mem_req), 1);
    check("st_wdata_held", 32'(mem_wdata), 32'hA5A5);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("st_req_drop", 32'(mem_req), 0);
    check("st_no_wb", 32'(wb_en), 0);
    check("st_retire", 32'(retire_cnt), 5);
    check("st_out_hold", 32'(wb_out), 32'h1234);

    // load timeout
    drive_mem(1'b0, 32'h0000_0100, 16'h0, 4'd9);
    step();
    exe_en = 1'b0;
    n = 0;
    while (mem_req && n < 200) begin
      n++;
      step();
    end
    check("to_req_cycles", 32'(n), 64);
    check("to_req", 32'(mem_req), 0);
    check("to_fault", 32'(mem_fault), 1);
    check("to_no_wb", 32'(wb_en), 0);
    check("to_retire", 32'(retire_cnt), 5);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    check("late_ack_wb", 32'(wb_en), 0);
    check("late_ack_req", 32'(mem_req), 0);
    check("late_ack_fault", 32'(mem_fault), 1);
    check("late_ack_retire", 32'(retire_cnt), 5);

    // load followed by held ALU op
    drive_mem(1'b0, 32'h0000_0044, 16'h0, 4'd6);
    step();
    drive_alu(4'd7, 16'h0042);
    step();
    check("hold_no_wb", 32'(wb_en), 0);
    check("hold_stall", 32'(wb_stall), 1);
    mem_ack = 1'b1; mem_rdata = 16'h5678;
    step();
    mem_ack = 1'b0;
    check("ord_ld_en", 32'(wb_en), 1);
    check("ord_ld_dst", 32'(wb_dst_reg), 6);
    check("ord_ld_out", 32'(wb_out), 32'h5678);
    check("ord_ld_retire", 32'(retire_cnt), 6);
    step();
    exe_en = 1'b0;
    check("ord_alu_en", 32'(wb_en), 1);
    check("ord_alu_dst", 32'(wb_dst_reg), 7);
    check("ord_alu_out", 32'(wb_out), 32'h0042);
    check("ord_alu_retire", 32'(retire_cnt), 7);
    step();
    check("ord_idle_en", 32'(wb_en), 0);

    // reset during MEM_WAIT
    drive_mem(1'b0, 32'h0000_0080, 16'h0, 4'd2);
    step();
    exe_en = 1'b0;
    step();
    check("rw_stall", 32'(wb_stall), 1);
    cpu_rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h9999;
    step();
    check("rw_req", 32'(mem_req), 0);
    check("rw_wb_en", 32'(wb_en), 0);
    check("rw_fault", 32'(mem_fault), 0);
    check("rw_retire", 32'(retire_cnt), 0);
    check("rw_stall0", 32'(wb_stall), 0);
    cpu_rst = 1'b0; mem_ack = 1'b0;
    step();
    check("rw_after_wb", 32'(wb_en), 0);
    check("rw_after_req", 32'(mem_req), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
